// File: rtl/regfile_if.sv
// Register file bus: two read ports, one write port, reservation/flush
// controls and the pending-count status.
//   master : decode/writeback side (drives addresses, write, reserve, flush)
//   slave  : register file (drives read data, ready flags, pending_cnt)
interface regfile_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              rs1_ready;
  logic              rs2_ready;
  logic              we;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              flush;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, rd_data, rsv_en, rsv_addr, flush,
    input  rs1_data, rs2_data, rs1_ready, rs2_ready, pending_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, rd_data, rsv_en, rsv_addr, flush,
    output rs1_data, rs2_data, rs1_ready, rs2_ready, pending_cnt
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Parametrised 2-read / 1-write integer register file with per-entry
// pending (scoreboard) bits, optional hardwired zero register and optional
// write-to-read bypass.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears data, pending bits, count)
//   rf    : regfile_if.slave -- read ports (combinational data/ready),
//           write port, reservation, flush, registered pending_cnt
module regfile_2r1w #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  regfile_if.slave rf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic wr_ok;
  logic rsv_ok;

  logic [ADDR_W-1:0] rd_port_addr [2];
  logic [XLEN-1:0]   rd_port_data [2];
  logic              rd_port_rdy  [2];

  // Entry 0 swallows writes and reservations when it is the zero register.
  assign wr_ok  = rf.we     && !(ZERO_REG && (rf.rd_addr  == '0));
  assign rsv_ok = rf.rsv_en && !(ZERO_REG && (rf.rsv_addr == '0));

  // Pending-bit update: write clears, reservation sets (wins), flush clears all.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) begin
      pend_d[rf.rd_addr] = 1'b0;
    end
    if (rsv_ok) begin
      pend_d[rf.rsv_addr] = 1'b1;
    end
    if (rf.flush) begin
      pend_d = '0;
    end
  end

  // Population count of the post-edge pending vector.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(pend_d[i]);
    end
  end

  // Storage, pending bits and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[rf.rd_addr] <= rf.rd_data;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_port_addr[0] = rf.rs1_addr;
  assign rd_port_addr[1] = rf.rs2_addr;

  // Read ports: zero register beats bypass, bypass beats stored state.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_port_data[p] = mem_q[rd_port_addr[p]];
      rd_port_rdy[p]  = !pend_q[rd_port_addr[p]];
      if (BYPASS && rf.we && (rf.rd_addr == rd_port_addr[p])) begin
        rd_port_data[p] = rf.rd_data;
        rd_port_rdy[p]  = 1'b1;
      end
      if (ZERO_REG && (rd_port_addr[p] == '0)) begin
        rd_port_data[p] = '0;
        rd_port_rdy[p]  = 1'b1;
      end
    end
  end

  assign rf.rs1_data    = rd_port_data[0];
  assign rf.rs2_data    = rd_port_data[1];
  assign rf.rs1_ready   = rd_port_rdy[0];
  assign rf.rs2_ready   = rd_port_rdy[1];
  assign rf.pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic clk;
  logic rst_n;

  regfile_if #(.XLEN(32), .ADDR_W(5)) ifa ();
  regfile_if #(.XLEN(32), .ADDR_W(5)) ifb ();
  regfile_if #(.XLEN(64), .ADDR_W(4)) ifc ();
  regfile_if #(.XLEN(64), .ADDR_W(4)) ifd ();

  // A: default config, B: no bypass, C/D: 64-bit x 16 with / without zero reg
  regfile_2r1w #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .rf(ifa));
  regfile_2r1w #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .rf(ifb));
  regfile_2r1w #(.XLEN(64), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_c (.clk(clk), .rst_n(rst_n), .rf(ifc));
  regfile_2r1w #(.XLEN(64), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1))
    dut_d (.clk(clk), .rst_n(rst_n), .rf(ifd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {
    A_RS1D, A_RS2D, A_RS1R, A_RS2R, A_CNT,
    B_RS2D, B_RS1R,
    C_RS1D, C_RS1R, C_CNT,
    D_RS1D, D_RS1R, D_CNT
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [63:0] K = 64'h0101010101010101;

  function automatic logic [63:0] obs(sel_e s);
    case (s)
      A_RS1D: return 64'(ifa.rs1_data);
      A_RS2D: return 64'(ifa.rs2_data);
      A_RS1R: return 64'(ifa.rs1_ready);
      A_RS2R: return 64'(ifa.rs2_ready);
      A_CNT:  return 64'(ifa.pending_cnt);
      B_RS2D: return 64'(ifb.rs2_data);
      B_RS1R: return 64'(ifb.rs1_ready);
      C_RS1D: return ifc.rs1_data;
      C_RS1R: return 64'(ifc.rs1_ready);
      C_CNT:  return 64'(ifc.pending_cnt);
      D_RS1D: return ifd.rs1_data;
      D_RS1R: return 64'(ifd.rs1_ready);
      D_CNT:  return 64'(ifd.pending_cnt);
      default: return 64'hX;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sel_e s, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [63:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.sel);
      n_chk++;
      assert (got === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    ifa.we = en; ifa.rd_addr = a; ifa.rd_data = d;
  endtask
  task automatic a_rsv(input logic en, input logic [4:0] a);
    ifa.rsv_en = en; ifa.rsv_addr = a;
  endtask
  task automatic a_rd(input logic [4:0] a1, input logic [4:0] a2);
    ifa.rs1_addr = a1; ifa.rs2_addr = a2;
  endtask
  task automatic b_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    ifb.we = en; ifb.rd_addr = a; ifb.rd_data = d;
  endtask
  task automatic cd_wr(input logic en, input logic [3:0] a, input logic [63:0] d);
    ifc.we = en; ifc.rd_addr = a; ifc.rd_data = d;
    ifd.we = en; ifd.rd_addr = a; ifd.rd_data = d;
  endtask
  task automatic cd_rsv(input logic en, input logic [3:0] a);
    ifc.rsv_en = en; ifc.rsv_addr = a;
    ifd.rsv_en = en; ifd.rsv_addr = a;
  endtask
  task automatic cd_rd(input logic [3:0] a);
    ifc.rs1_addr = a; ifc.rs2_addr = a;
    ifd.rs1_addr = a; ifd.rs2_addr = a;
  endtask

  task automatic idle_all();
    a_wr(1'b0, 5'd0, 32'd0); a_rsv(1'b0, 5'd0); a_rd(5'd0, 5'd0); ifa.flush = 1'b0;
    b_wr(1'b0, 5'd0, 32'd0); ifb.rsv_en = 1'b0; ifb.rsv_addr = 5'd0;
    ifb.rs1_addr = 5'd0; ifb.rs2_addr = 5'd0; ifb.flush = 1'b0;
    cd_wr(1'b0, 4'd0, 64'd0); cd_rsv(1'b0, 4'd0); cd_rd(4'd0);
    ifc.flush = 1'b0; ifd.flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    #12 rst_n = 1'b1;
    tick();

    // Build some state so the mid-cycle reset has something to clear
    a_wr(1'b1, 5'd1, 32'h0000FFFF); a_rsv(1'b1, 5'd31);
    tick();
    a_wr(1'b0, 5'd0, 32'd0); a_rsv(1'b0, 5'd0); a_rd(5'd1, 5'd31);
    #1;
    push_exp("pre_rst_x1", A_RS1D, 64'h0000FFFF);
    push_exp("pre_rst_x31_rdy", A_RS2R, 64'd0);
    push_exp("pre_rst_cnt", A_CNT, 64'd1);
    check();

    // Asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1;
    push_exp("rst_rs1_data", A_RS1D, 64'd0);
    push_exp("rst_rs2_data", A_RS2D, 64'd0);
    push_exp("rst_rs1_rdy", A_RS1R, 64'd1);
    push_exp("rst_rs2_rdy", A_RS2R, 64'd1);
    push_exp("rst_cnt", A_CNT, 64'd0);
    check();
    #8 rst_n = 1'b1;
    tick();

    // Write / readback, then zero register
    a_wr(1'b1, 5'd5, 32'hDEADBEEF); a_rd(5'd0, 5'd0);
    tick();
    a_wr(1'b0, 5'd0, 32'd0); a_rd(5'd5, 5'd5);
    #1;
    push_exp("wr_x5_rs1", A_RS1D, 64'hDEADBEEF);
    push_exp("wr_x5_rs2", A_RS2D, 64'hDEADBEEF);
    check();
    a_wr(1'b1, 5'd0, 32'h00001234); a_rd(5'd0, 5'd0);
    #1;
    push_exp("x0_no_bypass", A_RS1D, 64'd0);
    push_exp("x0_ready", A_RS1R, 64'd1);
    check();
    tick();
    a_wr(1'b0, 5'd0, 32'd0);
    #1;
    push_exp("x0_after_wr", A_RS2D, 64'd0);
    check();

    // Bypass (A) versus no bypass (B)
    a_rd(5'd5, 5'd7); a_wr(1'b1, 5'd7, 32'hA5A5A5A5);
    ifb.rs2_addr = 5'd7; b_wr(1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
    push_exp("byp_a_rs2", A_RS2D, 64'hA5A5A5A5);
    push_exp("byp_a_rs1_other", A_RS1D, 64'hDEADBEEF);
    push_exp("nobyp_b_old", B_RS2D, 64'd0);
    check();
    tick();
    a_wr(1'b0, 5'd0, 32'd0); b_wr(1'b0, 5'd0, 32'd0);
    #1;
    push_exp("nobyp_b_new", B_RS2D, 64'hA5A5A5A5);
    push_exp("byp_a_held", A_RS2D, 64'hA5A5A5A5);
    check();

    // No-bypass ready: pending entry stays not-ready until after the write edge
    ifb.rsv_en = 1'b1; ifb.rsv_addr = 5'd8; ifb.rs1_addr = 5'd8;
    tick();
    ifb.rsv_en = 1'b0; b_wr(1'b1, 5'd8, 32'h00000042);
    #1;
    push_exp("nobyp_b_rdy_pre", B_RS1R, 64'd0);
    check();
    tick();
    b_wr(1'b0, 5'd0, 32'd0);
    #1;
    push_exp("nobyp_b_rdy_post", B_RS1R, 64'd1);
    check();

    // Scoreboard on x3
    a_rsv(1'b1, 5'd3); a_rd(5'd3, 5'd3);
    #1;
    push_exp("rsv_x3_same_cycle", A_RS1R, 64'd1);
    check();
    tick();
    a_rsv(1'b0, 5'd0);
    #1;
    push_exp("rsv_x3_rdy", A_RS1R, 64'd0);
    push_exp("rsv_x3_cnt", A_CNT, 64'd1);
    check();
    a_wr(1'b1, 5'd3, 32'h00000055);
    #1;
    push_exp("wr_x3_byp_rdy", A_RS1R, 64'd1);
    push_exp("wr_x3_byp_data", A_RS1D, 64'h55);
    check();
    tick();
    a_wr(1'b0, 5'd0, 32'd0);
    #1;
    push_exp("wr_x3_rdy", A_RS1R, 64'd1);
    push_exp("wr_x3_cnt", A_CNT, 64'd0);
    push_exp("wr_x3_data", A_RS2D, 64'h55);
    check();
    a_wr(1'b1, 5'd3, 32'h00000077); a_rsv(1'b1, 5'd3);
    tick();
    a_wr(1'b0, 5'd0, 32'd0); a_rsv(1'b0, 5'd0);
    #1;
    push_exp("wr_rsv_x3_rdy", A_RS1R, 64'd0);
    push_exp("wr_rsv_x3_data", A_RS1D, 64'h77);
    push_exp("wr_rsv_x3_cnt", A_CNT, 64'd1);
    check();
    a_wr(1'b1, 5'd3, 32'h00000088);
    tick();
    a_wr(1'b0, 5'd0, 32'd0);

    // Flush precedence over same-cycle reservation; write still lands
    a_rsv(1'b1, 5'd1); tick();
    a_rsv(1'b1, 5'd2); tick();
    a_rsv(1'b1, 5'd4); tick();
    a_rsv(1'b0, 5'd0); a_rd(5'd1, 5'd2);
    #1;
    push_exp("pre_flush_cnt", A_CNT, 64'd3);
    push_exp("pre_flush_x1", A_RS1R, 64'd0);
    push_exp("pre_flush_x2", A_RS2R, 64'd0);
    check();
    ifa.flush = 1'b1; a_rsv(1'b1, 5'd6); a_wr(1'b1, 5'd9, 32'h0000CAFE);
    tick();
    ifa.flush = 1'b0; a_rsv(1'b0, 5'd0); a_wr(1'b0, 5'd0, 32'd0);
    #1;
    push_exp("flush_cnt", A_CNT, 64'd0);
    push_exp("flush_x1", A_RS1R, 64'd1);
    push_exp("flush_x2", A_RS2R, 64'd1);
    check();
    a_rd(5'd4, 5'd6);
    #1;
    push_exp("flush_x4", A_RS1R, 64'd1);
    push_exp("flush_x6", A_RS2R, 64'd1);
    check();
    a_rd(5'd9, 5'd9);
    #1;
    push_exp("flush_wr_x9", A_RS1D, 64'h0000CAFE);
    check();

    // 64-bit x 16 sweep, with and without zero register
    for (int i = 0; i < 16; i++) begin
      cd_wr(1'b1, 4'(i), 64'(i) * K);
      tick();
    end
    cd_wr(1'b0, 4'd0, 64'd0);
    for (int i = 0; i < 16; i++) begin
      cd_rd(4'(i));
      #1;
      push_exp("sweep_c_data", C_RS1D, 64'(i) * K);
      push_exp("sweep_d_data", D_RS1D, 64'(i) * K);
      check();
    end
    for (int i = 0; i < 16; i++) begin
      cd_rsv(1'b1, 4'(i));
      tick();
    end
    cd_rsv(1'b0, 4'd0); cd_rd(4'd0);
    #1;
    push_exp("sweep_c_cnt", C_CNT, 64'd15);
    push_exp("sweep_d_cnt", D_CNT, 64'd16);
    push_exp("sweep_c_x0_rdy", C_RS1R, 64'd1);
    push_exp("sweep_d_x0_rdy", D_RS1R, 64'd0);
    check();
    cd_rd(4'd15);
    #1;
    push_exp("sweep_c_x15_rdy", C_RS1R, 64'd0);
    check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised integer register file for the datapath: two combinational read ports, one synchronous write port, and a per-register pending (scoreboard) bit. It generalises the fixed 32-entry, 32-bit read-select mux into a configurable-width and configurable-depth storage block. It adds a hardwired zero register, optional write-to-read bypass, and hazard tracking. It sits between decode (read/reserve) and writeback (write).

## Interface
- XLEN, 32, data width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes and reservations
- BYPASS, 1, 1: same-cycle write data forwarded to matching read port
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- rs1_ready  out  1  entry at rs1_addr has no outstanding reservation, or is satisfied by bypass
- rs2_ready  out  1  same for rs2_addr
- we  in  1  write enable
- rd_addr  in  ADDR_W  write address
- rd_data  in  XLEN  write data
- rsv_en  in  1  reserve (mark pending) entry rsv_addr
- rsv_addr  in  ADDR_W  reservation address
- flush  in  1  synchronous clear of all pending bits
- pending_cnt  out  ADDR_W+1  number of entries currently pending (registered)

## Operation
- Storage: mem[0..2**ADDR_W-1], each XLEN bits; pend[0..2**ADDR_W-1], 1 bit each.
- Write: on the rising edge, if we is high, mem[rd_addr] <= rd_data and pend[rd_addr] is cleared. When ZERO_REG=1 and rd_addr=0, nothing happens.
- Reserve: on the rising edge, if rsv_en is high, pend[rsv_addr] <= 1. Ignored for address 0 when ZERO_REG=1.
- Same-edge write and reserve to the same address: the data is written and pend ends at 1 (the new reservation wins).
- flush: on the edge, all pend bits are cleared. flush overrides a same-cycle rsv_en. A same-cycle write still updates mem.
- Read (combinational), for each port X:
  - If ZERO_REG=1 and rsX_addr=0: rsX_data=0 and rsX_ready=1.
  - Otherwise, if BYPASS=1, we=1 and rd_addr=rsX_addr: rsX_data=rd_data and rsX_ready=1.
  - Otherwise: rsX_data=mem[rsX_addr] and rsX_ready=!pend[rsX_addr].
- pending_cnt: register holding the population count of pend after each edge's update. Its range is 0..2**ADDR_W. It can never exceed 2**ADDR_W-1 when ZERO_REG=1.
- Both ports may address the same entry; the two outputs are then identical.

## Timing
- Reset (rst_n low, asynchronous): all mem entries = 0, all pend = 0, pending_cnt = 0. While reset is held, rsX_data=0 and rsX_ready=1 for all addresses, except for bypass of the current write inputs when BYPASS=1.
- Reset mid-operation clears everything immediately. The first edge after rst_n rises performs normal updates.
- Read latency is 0 cycles (combinational).
- Write-to-read latency:
  - BYPASS=1: visible the same cycle.
  - BYPASS=0: visible the cycle after the write edge.
- Reserve-to-not-ready latency is 1 edge. pending_cnt reflects the change in the cycle after the edge.
- No handshake stalls: every write, reserve and flush is accepted every cycle.

## Test plan
- Reset then read: with rst_n pulsed low asynchronously mid-cycle, reading addresses 1 and 31 -> rs1_data=rs2_data=0, both ready=1, pending_cnt=0.
- Write/readback: write 0xDEADBEEF to x5, then read rs1=5 and rs2=5 next cycle -> both 0xDEADBEEF. Write 0x1234 to x0 -> reading x0 returns 0 (ZERO_REG=1).
- Bypass: with BYPASS=1, write x7=0xA5A5A5A5 while rs2_addr=7 in the same cycle -> rs2_data=0xA5A5A5A5 before the edge. Repeat with BYPASS=0 -> old value until after the edge.
- Scoreboard: reserve x3 -> next cycle rs1_ready=0 for addr 3 and pending_cnt=1. Write x3=0x55 -> ready=1 and pending_cnt=0. Write and reserve x3 on the same edge -> ready=0 and data=new value.
- Flush precedence: reserve x1, x2, x4 (pending_cnt=3), then assert flush together with rsv_en on x6 -> pending_cnt=0 and all four ready=1.
- Parametrised sweep: XLEN=64 with ADDR_W=4, write all 16 entries with value = index*0x0101010101010101 -> all entries read back correctly. Reserve all entries -> pending_cnt=15 with ZERO_REG=1, and 16 with ZERO_REG=0.
